// File: rtl/wfg_wb_pkg.sv
// Shared types for the waveform-generator bus initiators.
package wfg_wb_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBus  = 2'd1,
      StResp = 2'd2
   } wb_state_e;

endpackage

// File: rtl/wfg_wb_master.sv
// Wishbone B4 classic single-transfer initiator: one command in, one bus cycle, one response out.
module wfg_wb_master
   import wfg_wb_pkg::*;
#(
   parameter int unsigned BUSW    = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,

   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_we_i,
   input  logic [BUSW-1:0]   cmd_adr_i,
   input  logic [BUSW/8-1:0] cmd_sel_i,
   input  logic [BUSW-1:0]   cmd_dat_i,

   output logic              wbm_cyc_o,
   output logic              wbm_stb_o,
   output logic              wbm_we_o,
   output logic [BUSW/8-1:0] wbm_sel_o,
   output logic [BUSW-1:0]   wbm_adr_o,
   output logic [BUSW-1:0]   wbm_dat_o,
   input  logic              wbm_ack_i,
   input  logic [BUSW-1:0]   wbm_dat_i,

   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [BUSW-1:0]   rsp_dat_o,
   output logic              rsp_err_o,
   output logic              busy_o
);

   localparam int unsigned SelW = BUSW / 8;
   localparam int unsigned CntW = $clog2(TIMEOUT + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

   wb_state_e         state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              cyc_q, cyc_d;
   logic              we_q, we_d;
   logic [SelW-1:0]   sel_q, sel_d;
   logic [BUSW-1:0]   adr_q, adr_d;
   logic [BUSW-1:0]   dat_q, dat_d;
   logic [BUSW-1:0]   rsp_dat_q, rsp_dat_d;
   logic              rsp_err_q, rsp_err_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cyc_d     = cyc_q;
      we_d      = we_q;
      sel_d     = sel_q;
      adr_d     = adr_q;
      dat_d     = dat_q;
      rsp_dat_d = rsp_dat_q;
      rsp_err_d = rsp_err_q;

      unique case (state_q)
         StIdle: begin
            if (cmd_valid_i) begin
               we_d    = cmd_we_i;
               sel_d   = cmd_sel_i;
               adr_d   = cmd_adr_i;
               dat_d   = cmd_dat_i;
               cnt_d   = '0;
               cyc_d   = 1'b1;
               state_d = StBus;
            end
         end
         StBus: begin
            // ACK takes priority over a timeout firing in the same cycle.
            if (wbm_ack_i) begin
               cyc_d     = 1'b0;
               rsp_dat_d = we_q ? '0 : wbm_dat_i;
               rsp_err_d = 1'b0;
               state_d   = StResp;
            end else if (cnt_q == CntLast) begin
               cyc_d     = 1'b0;
               rsp_dat_d = '0;
               rsp_err_d = 1'b1;
               state_d   = StResp;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StResp: begin
            if (rsp_ready_i) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            cyc_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         cyc_q     <= 1'b0;
         we_q      <= 1'b0;
         sel_q     <= '0;
         adr_q     <= '0;
         dat_q     <= '0;
         rsp_dat_q <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cyc_q     <= cyc_d;
         we_q      <= we_d;
         sel_q     <= sel_d;
         adr_q     <= adr_d;
         dat_q     <= dat_d;
         rsp_dat_q <= rsp_dat_d;
         rsp_err_q <= rsp_err_d;
      end
   end

   assign cmd_ready_o = (state_q == StIdle);
   assign busy_o      = (state_q != StIdle);
   assign rsp_valid_o = (state_q == StResp);
   assign rsp_dat_o   = rsp_dat_q;
   assign rsp_err_o   = rsp_err_q;
   assign wbm_cyc_o   = cyc_q;
   assign wbm_stb_o   = cyc_q;
   assign wbm_we_o    = we_q;
   assign wbm_sel_o   = sel_q;
   assign wbm_adr_o   = adr_q;
   assign wbm_dat_o   = dat_q;

endmodule

// File: tb/tb_wfg_wb_master.sv
// Directed and randomized checks of wfg_wb_master against a small register-file slave.
module tb_wfg_wb_master;

   logic        clk, rst;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [31:0] cmd_adr, cmd_dat;
   logic [3:0]  cmd_sel;
   logic        wbm_cyc, wbm_stb, wbm_we, wbm_ack;
   logic [3:0]  wbm_sel;
   logic [31:0] wbm_adr, wbm_dat_o, wbm_dat_i;
   logic        rsp_valid, rsp_ready, rsp_err, busy;
   logic [31:0] rsp_dat;

   int vecs = 0;
   int errs = 0;

   // Slave model: ACK after slv_wait extra cycles, optionally never; spur_ack forces ACK.
   int          slv_wait = 0;
   logic        slv_never = 1'b0;
   logic        spur_ack = 1'b0;
   int          slv_cnt;
   logic [31:0] slv_mem [16];
   logic [31:0] exp_mem [16];

   wfg_wb_master #(
      .BUSW    (32),
      .TIMEOUT (8)
   ) dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_we_i    (cmd_we),
      .cmd_adr_i   (cmd_adr),
      .cmd_sel_i   (cmd_sel),
      .cmd_dat_i   (cmd_dat),
      .wbm_cyc_o   (wbm_cyc),
      .wbm_stb_o   (wbm_stb),
      .wbm_we_o    (wbm_we),
      .wbm_sel_o   (wbm_sel),
      .wbm_adr_o   (wbm_adr),
      .wbm_dat_o   (wbm_dat_o),
      .wbm_ack_i   (wbm_ack),
      .wbm_dat_i   (wbm_dat_i),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_dat_o   (rsp_dat),
      .rsp_err_o   (rsp_err),
      .busy_o      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!wbm_cyc) slv_cnt <= 0;
      else          slv_cnt <= slv_cnt + 1;
      if (wbm_cyc && wbm_stb && wbm_ack && wbm_we) begin
         for (int b = 0; b < 4; b++)
            if (wbm_sel[b]) slv_mem[wbm_adr[5:2]][8*b +: 8] <= wbm_dat_o[8*b +: 8];
      end
   end

   assign wbm_ack   = spur_ack | (wbm_cyc & wbm_stb & !slv_never & (slv_cnt == slv_wait));
   assign wbm_dat_i = slv_mem[wbm_adr[5:2]];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one command, count cycles with CYC high until the response appears.
   task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat, output int ncyc);
      cmd_valid = 1'b1;
      cmd_we    = we;
      cmd_adr   = adr;
      cmd_sel   = sel;
      cmd_dat   = dat;
      chk("cmd_ready_before", cmd_ready, 1'b1);
      tick();
      cmd_valid = 1'b0;
      chk("cyc_after_accept", wbm_cyc, 1'b1);
      chk("stb_after_accept", wbm_stb, 1'b1);
      chk("adr_on_bus", wbm_adr, adr);
      chk("we_on_bus", wbm_we, we);
      chk("sel_on_bus", wbm_sel, sel);
      if (we) chk("dat_on_bus", wbm_dat_o, dat);
      ncyc = 0;
      for (int i = 0; i < 40 && !rsp_valid; i++) begin
         if (wbm_cyc) ncyc++;
         tick();
      end
      chk("rsp_valid_arrives", rsp_valid, 1'b1);
      chk("cyc_low_in_resp", wbm_cyc, 1'b0);
   endtask

   task automatic consume();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("rsp_valid_dropped", rsp_valid, 1'b0);
      chk("cmd_ready_back", cmd_ready, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      int          idx;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] dat;

      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_we    = 1'b0;
      cmd_adr   = '0;
      cmd_sel   = '0;
      cmd_dat   = '0;
      rsp_ready = 1'b0;
      #3;
      chk("rst_cyc", wbm_cyc, 1'b0);
      chk("rst_stb", wbm_stb, 1'b0);
      chk("rst_we", wbm_we, 1'b0);
      chk("rst_sel", wbm_sel, 4'h0);
      chk("rst_adr", wbm_adr, 32'h0);
      chk("rst_dat", wbm_dat_o, 32'h0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_dat", rsp_dat, 32'h0);
      chk("rst_rsp_err", rsp_err, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      tick();

      // Zero-wait write: one CYC cycle, response two cycles after accept.
      slv_wait = 0;
      run_cmd(1'b1, 32'h04, 4'hF, 32'h0000_1234, n);
      chk("w0_cyc_cycles", n, 1);
      chk("w0_err", rsp_err, 1'b0);
      chk("w0_dat", rsp_dat, 32'h0);
      chk("w0_busy", busy, 1'b1);
      chk("w0_cmd_ready", cmd_ready, 1'b0);
      consume();
      chk("adr_held_after_cycle", wbm_adr, 32'h04);

      run_cmd(1'b1, 32'h08, 4'hF, 32'hDEAD_BEEF, n);
      consume();

      // Three-wait read.
      slv_wait = 3;
      run_cmd(1'b0, 32'h08, 4'hF, 32'h0, n);
      chk("r3_cyc_cycles", n, 4);
      chk("r3_dat", rsp_dat, 32'hDEAD_BEEF);
      chk("r3_err", rsp_err, 1'b0);
      consume();

      // Timeout: slave never answers.
      slv_never = 1'b1;
      run_cmd(1'b0, 32'h10, 4'hF, 32'h0, n);
      chk("to_cyc_cycles", n, 8);
      chk("to_err", rsp_err, 1'b1);
      chk("to_dat", rsp_dat, 32'h0);
      consume();
      slv_never = 1'b0;

      // ACK on the last allowed cycle beats the timeout.
      slv_wait = 7;
      run_cmd(1'b0, 32'h04, 4'hF, 32'h0, n);
      chk("late_ack_cyc_cycles", n, 8);
      chk("late_ack_err", rsp_err, 1'b0);
      chk("late_ack_dat", rsp_dat, 32'h0000_1234);
      consume();

      // Backpressure with spurious ACKs while the response waits.
      slv_wait = 1;
      run_cmd(1'b0, 32'h08, 4'hF, 32'h0, n);
      spur_ack = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_rsp_valid", rsp_valid, 1'b1);
         chk("bp_rsp_dat", rsp_dat, 32'hDEAD_BEEF);
         chk("bp_rsp_err", rsp_err, 1'b0);
         chk("bp_cmd_ready", cmd_ready, 1'b0);
         chk("bp_cyc", wbm_cyc, 1'b0);
      end
      spur_ack = 1'b0;
      consume();
      spur_ack = 1'b1;
      tick();
      chk("idle_spur_cyc", wbm_cyc, 1'b0);
      chk("idle_spur_busy", busy, 1'b0);
      chk("idle_spur_rsp_valid", rsp_valid, 1'b0);
      spur_ack = 1'b0;

      // Reset during the second BUS cycle of a three-wait read.
      slv_wait = 3;
      cmd_valid = 1'b1;
      cmd_we    = 1'b0;
      cmd_adr   = 32'h08;
      cmd_sel   = 4'hF;
      tick();
      cmd_valid = 1'b0;
      tick();
      chk("pre_rst_cyc", wbm_cyc, 1'b1);
      rst = 1'b1;
      #1;
      chk("mid_rst_cyc", wbm_cyc, 1'b0);
      chk("mid_rst_stb", wbm_stb, 1'b0);
      chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("post_rst_cmd_ready", cmd_ready, 1'b1);
      chk("post_rst_cyc", wbm_cyc, 1'b0);
      slv_wait = 0;
      run_cmd(1'b1, 32'h0C, 4'hF, 32'hCAFE_0001, n);
      chk("post_rst_w_cycles", n, 1);
      chk("post_rst_w_err", rsp_err, 1'b0);
      consume();

      // Fill the register file, then random back-to-back traffic.
      for (int i = 0; i < 16; i++) begin
         dat = $urandom;
         slv_wait = $urandom_range(0, 3);
         run_cmd(1'b1, 32'(i * 4), 4'hF, dat, n);
         exp_mem[i] = dat;
         chk("fill_err", rsp_err, 1'b0);
         consume();
      end
      for (int k = 0; k < 100; k++) begin
         idx      = $urandom_range(0, 15);
         we       = 1'($urandom_range(0, 1));
         sel      = 4'($urandom_range(1, 15));
         dat      = $urandom;
         slv_wait = $urandom_range(0, 3);
         run_cmd(we, 32'(idx * 4), sel, dat, n);
         chk("rnd_cycles", n, slv_wait + 1);
         chk("rnd_err", rsp_err, 1'b0);
         if (we) begin
            for (int b = 0; b < 4; b++)
               if (sel[b]) exp_mem[idx][8*b +: 8] = dat[8*b +: 8];
            chk("rnd_wr_dat", rsp_dat, 32'h0);
         end else begin
            chk("rnd_rd_dat", rsp_dat, exp_mem[idx]);
         end
         consume();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/wfg_wb_master.md
# wfg_wb_master

Wishbone classic single-transfer initiator for the waveform-generator subsystem: accepts one read/write command on a valid/ready interface, drives it onto the Wishbone bus toward a register-slave peripheral, and returns read data or a timeout error on a valid/ready response interface. It lets a controller or sequencer program peripheral registers without its own bus logic. Bus timing follows Wishbone B4 classic cycles, one transfer per CYC.

## Interface
- BUSW, 32: data/address width; must be a multiple of 8.
- TIMEOUT, 255: maximum cycles CYC/STB stay asserted without ACK; legal range 1..65535.

- wb_clk_i  in  1  clock; all logic on rising edge
- wb_rst_i  in  1  reset, asynchronous, active-high
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when both high at an edge
- cmd_we_i  in  1  1 = write, 0 = read
- cmd_adr_i  in  BUSW  byte address
- cmd_sel_i  in  BUSW/8  byte enables
- cmd_dat_i  in  BUSW  write data
- wbm_cyc_o, wbm_stb_o  out  1 each  bus cycle / strobe (registered)
- wbm_we_o  out  1  write enable
- wbm_sel_o  out  BUSW/8  byte enables
- wbm_adr_o  out  BUSW  address
- wbm_dat_o  out  BUSW  write data
- wbm_ack_i  in  1  slave acknowledge
- wbm_dat_i  in  BUSW  slave read data
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  response consumed when both high at an edge
- rsp_dat_o  out  BUSW  read data (0 for writes and errors)
- rsp_err_o  out  1  1 = timeout, no ACK received
- busy_o  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, BUS, RESP. Reset state IDLE.
- IDLE: cmd_ready_o = 1. On cmd_valid_i & cmd_ready_o: latch we/adr/sel/dat into the wbm_* registers, clear timeout counter, go BUS.
- BUS: wbm_cyc_o = wbm_stb_o = 1, address/data/sel/we stable throughout.
  - wbm_ack_i high: deassert cyc/stb, capture wbm_dat_i into rsp_dat_o if read (0 if write), rsp_err_o = 0, go RESP.
  - else counter == TIMEOUT-1: deassert cyc/stb, rsp_dat_o = 0, rsp_err_o = 1, go RESP.
  - else counter increments.
  - ACK on the same cycle the timeout would fire: ACK wins, rsp_err_o = 0.
- RESP: rsp_valid_o = 1, rsp_dat_o/rsp_err_o stable until rsp_valid_o & rsp_ready_i, then IDLE.
- wbm_ack_i outside BUS is ignored; no state or output change.
- wbm_adr_o/wbm_dat_o/wbm_sel_o/wbm_we_o hold last values after the cycle ends; only cyc/stb qualify them.
- Counter width $clog2(TIMEOUT+1); never wraps (exit occurs at TIMEOUT-1).

## Timing
- Reset values: wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, rsp_valid_o, rsp_dat_o, rsp_err_o, busy_o all 0; cmd_ready_o 1.
- Accept at edge N → cyc/stb high from N+1.
- ACK sampled high at edge K → cyc/stb low and rsp_valid_o high from K+1 (same edge).
- Zero-wait slave (ACK combinational in first BUS cycle): accept→rsp_valid_o = 2 cycles.
- Timeout: cyc/stb high for exactly TIMEOUT cycles, rsp_valid_o rises the edge they fall.
- Response consumed at edge R → cmd_ready_o high from R+1; minimum command-to-command spacing 3 cycles.
- Reset asserted mid-transfer: cyc/stb and rsp_valid_o fall asynchronously; in-flight command and pending response discarded; no ACK-dependent state survives.

## Structure
- Package wfg_wb_pkg: state enum (IDLE, BUS, RESP) typedef; shared by future bus initiators in the subsystem.
- Single module; timeout counter inline (no sub-module needed). No combinational path from wbm_ack_i to any wbm_* output.

## Test plan
- Write, zero-wait slave: cmd we=1 adr=0x04 sel=0xF dat=0x0000_1234 → one cycle of cyc/stb with those values, rsp_valid_o 2 cycles after accept, rsp_err_o=0, rsp_dat_o=0.
- Read, 3-wait slave returning 0xDEAD_BEEF at adr=0x08 → cyc/stb high 4 cycles, rsp_dat_o=0xDEAD_BEEF, rsp_err_o=0.
- Timeout, TIMEOUT=8, slave never ACKs → cyc/stb high exactly 8 cycles, rsp_err_o=1, rsp_dat_o=0; ACK on the 8th cycle instead → rsp_err_o=0.
- Backpressure: rsp_ready_i low 5 cycles → rsp_valid_o/rsp_dat_o held, cmd_ready_o=0, cyc/stb low, spurious ACK ignored.
- Reset mid-BUS (cycle 2 of a 3-wait read) → cyc/stb, rsp_valid_o low immediately; after release cmd_ready_o=1 and next write completes normally.
- 100 random back-to-back commands against a register-file model → every read returns the last written value per address, no err.
